// File: rtl/multdiv_unit_if.sv
// Operand/command and result bundle for multdiv_unit.
// The requester drives the master side; the unit sits on the slave side.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             ctrl_REM;
  logic             op_signed;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_REM, op_signed,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, ctrl_REM, op_signed,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative multiply / divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, sign fix-up in a final cycle.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  multdiv_unit_if.slave     bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_REM} op_t;

  state_t state, next_state;
  op_t    op, start_op;

  logic             start, last;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, addend;
  logic             sgn, neg_a, neg_b, div_zero, div_ovf;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_exc;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV | bus.ctrl_REM;
  assign last  = (cnt == CW'(WIDTH));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    start_op = OP_REM;
    if (bus.ctrl_MULT)     start_op = OP_MUL;
    else if (bus.ctrl_DIV) start_op = OP_DIV;
  end

  assign mag_a = (bus.op_signed && bus.data_operandA[WIDTH-1]) ? -bus.data_operandA
                                                               : bus.data_operandA;
  assign mag_b = (bus.op_signed && bus.data_operandB[WIDTH-1]) ? -bus.data_operandB
                                                               : bus.data_operandB;

  // A new start always wins, so it also aborts RUN and DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = IDLE;
      RUN:     if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (start) next_state = RUN;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // One iteration step: {hi,lo} is the product/multiplier pair or the
  // partial remainder/quotient pair, addend the multiplicand or divisor.
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, addend} : '0);
  assign div_shift = {hi, lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, addend});
  assign div_diff  = div_shift[WIDTH-1:0] - addend;

  assign prod_mag = {hi, lo};
  assign prod     = (neg_a ^ neg_b) ? -prod_mag : prod_mag;

  always_comb begin
    fin_result = '0;
    fin_exc    = 1'b0;
    case (op)
      OP_MUL: begin
        fin_result = prod[WIDTH-1:0];
        fin_exc    = sgn ? !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]))
                         : (|prod[2*WIDTH-1:WIDTH]);
      end
      OP_DIV: begin
        if (div_zero) begin
          fin_exc = 1'b1;
        end else if (div_ovf) begin
          fin_result = MOST_NEG;
          fin_exc    = 1'b1;
        end else begin
          fin_result = (neg_a ^ neg_b) ? -lo : lo;
        end
      end
      default: begin
        if (div_zero) fin_exc    = 1'b1;
        else          fin_result = neg_a ? -hi : hi;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: all datapath registers are reset; the unit has no memory arrays.
    if (!reset_n) begin
      op       <= OP_MUL;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      addend   <= '0;
      sgn      <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (start) begin
      op       <= start_op;
      cnt      <= '0;
      hi       <= '0;
      sgn      <= bus.op_signed;
      neg_a    <= bus.op_signed & bus.data_operandA[WIDTH-1];
      neg_b    <= bus.op_signed & bus.data_operandB[WIDTH-1];
      div_zero <= (bus.data_operandB == '0);
      div_ovf  <= bus.op_signed && (bus.data_operandA == MOST_NEG) && (bus.data_operandB == '1);
      addend   <= (start_op == OP_MUL) ? mag_a : mag_b;
      lo       <= (start_op == OP_MUL) ? mag_b : mag_a;
    end else if (state == RUN) begin
      if (last) begin
        result_q <= fin_result;
        exc_q    <= fin_exc;
      end else begin
        cnt <= cnt + 1'b1;
        if (op == OP_MUL) begin
          hi <= mul_sum[WIDTH:1];
          lo <= {mul_sum[0], lo[WIDTH-1:1]};
        end else begin
          hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], div_ge};
        end
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state != IDLE);
endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_multdiv_unit;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  multdiv_unit_if #(.WIDTH(W)) bus ();

  multdiv_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ctrl = {MULT, DIV, REM}; priority MULT > DIV > REM.
  function automatic void model(input logic [2:0] ctrl, input logic sgn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e);
    longint      sa, sb, p;
    logic [63:0] up;
    logic        want_rem;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    e  = 1'b0;
    want_rem = !ctrl[1];
    if (ctrl[2]) begin
      if (sgn) begin
        p = sa * sb;
        r = p[W-1:0];
        e = (p != longint'($signed(p[W-1:0])));
      end else begin
        up = {32'b0, a} * {32'b0, b};
        r  = up[W-1:0];
        e  = (up[63:W] != 0);
      end
    end else if (b == 0) begin
      r = '0;
      e = 1'b1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r = want_rem ? 32'h0 : 32'h8000_0000;
        e = !want_rem;
      end else begin
        p = want_rem ? (sa % sb) : (sa / sb);
        r = p[W-1:0];
      end
    end else begin
      r = want_rem ? (a % b) : (a / b);
    end
  endfunction

  task automatic drive_start(input logic [2:0] ctrl, input logic sgn,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.op_signed     = sgn;
    bus.ctrl_MULT     = ctrl[2];
    bus.ctrl_DIV      = ctrl[1];
    bus.ctrl_REM      = ctrl[0];
  endtask

  // Releases the start pulse and scrambles the operands so latching is exercised.
  task automatic end_start();
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.ctrl_REM      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    bus.op_signed     = 1'($urandom_range(1));
  endtask

  task automatic run_op(input string tag, input logic [2:0] ctrl, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic         ee;
    int           lat;
    model(ctrl, sgn, a, b, er, ee);
    @(negedge clock);
    drive_start(ctrl, sgn, a, b);
    @(posedge clock);
    #1;
    end_start();
    check({tag, "_busy_start"}, bus.busy, 1);
    lat = 0;
    while (!bus.data_resultRDY && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_result"}, bus.data_result, er);
    check({tag, "_exc"}, bus.data_exception, ee);
    check({tag, "_busy_rdy"}, bus.busy, 1);
    @(posedge clock);
    #1;
    check({tag, "_rdy_single"}, bus.data_resultRDY, 0);
    check({tag, "_busy_end"}, bus.busy, 0);
    check({tag, "_hold"}, bus.data_result, er);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(20));
      4:       return -32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]   ctrl;
    int           pulses, lat;
    logic [W-1:0] res_at_rdy;

    reset_n = 1'b0;
    drive_start(3'b000, 1'b0, '0, '0);
    #12;
    check("reset_result", bus.data_result, 0);
    check("reset_exc", bus.data_exception, 0);
    check("reset_rdy", bus.data_resultRDY, 0);
    check("reset_busy", bus.busy, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("mul_7_m3",    3'b100, 1'b1, 32'd7, -32'd3);
    run_op("mul_u_ovf",   3'b100, 1'b0, 32'h0001_0000, 32'h0001_0000);
    run_op("mul_s_8000",  3'b100, 1'b1, 32'h0000_8000, 32'h0000_8000);
    run_op("div_m7_2",    3'b010, 1'b1, -32'd7, 32'd2);
    run_op("rem_m7_2",    3'b001, 1'b1, -32'd7, 32'd2);
    run_op("div_by_zero", 3'b010, 1'b0, 32'd55, 32'd0);
    run_op("rem_by_zero", 3'b001, 1'b1, 32'd55, 32'd0);
    run_op("div_min_m1",  3'b010, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_min_m1",  3'b001, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_zero_a",  3'b010, 1'b1, 32'd0, -32'd9);
    run_op("prio_all",    3'b111, 1'b1, 32'd7, -32'd3);
    run_op("prio_div",    3'b011, 1'b0, 32'd100, 32'd7);

    for (int i = 0; i < 40; i++) begin
      ctrl = 3'(1 << $urandom_range(2));
      if ($urandom_range(7) == 0) ctrl = 3'($urandom_range(7, 1));
      run_op($sformatf("rnd%0d", i), ctrl, 1'($urandom_range(1)), pick(), pick());
    end

    // Abort: DIV started 10 edges after a MULT replaces it.
    @(negedge clock);
    drive_start(3'b100, 1'b0, 32'd5, 32'd9);
    @(posedge clock);
    #1;
    end_start();
    pulses = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) pulses++;
    end
    drive_start(3'b010, 1'b0, 32'd100, 32'd7);
    @(posedge clock);
    #1;
    end_start();
    lat = 0;
    res_at_rdy = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          res_at_rdy = bus.data_result;
        end
      end
    end
    check("abort_pulses", pulses, 1);
    check("abort_latency", lat, LAT);
    check("abort_result", res_at_rdy, 14);

    // Reset in the middle of a DIV; a start during reset must be ignored.
    @(negedge clock);
    drive_start(3'b010, 1'b0, 32'd1000, 32'd3);
    @(posedge clock);
    #1;
    end_start();
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_result", bus.data_result, 0);
    check("midrst_exc", bus.data_exception, 0);
    check("midrst_rdy", bus.data_resultRDY, 0);
    check("midrst_busy", bus.busy, 0);
    drive_start(3'b100, 1'b0, 32'd3, 32'd3);
    @(posedge clock);
    #1;
    end_start();
    check("rst_start_ignored", bus.busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) pulses++;
    end
    check("postrst_pulses", pulses, 0);
    check("postrst_busy", bus.busy, 0);

    run_op("after_rst", 3'b001, 1'b1, 32'd47, -32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
